quad_sum_ctrl: RTL and testbench
================================

# quad_sum_ctrl

Join/sequencing controller for the four-input sample adder. It accepts four AXI4-Stream sample channels, admits a beat only when every enabled channel presents one, and sums aligned beats lane-by-lane with signed saturation. It enforces frame alignment on tlast and flushes misaligned channels to the next frame boundary. It sits between the four channel front-ends and the downstream beamforming/capture path, with a registered output stage.

## Interface
- SDATA_WIDTH, 256, beat width of every stream
- SSAMPLE_WIDTH, 16, signed sample width; lanes = SDATA_WIDTH/SSAMPLE_WIDTH
- CLK  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- cfg_enable_mask  in  4  per-channel enable; latched on start
- cfg_start  in  1  pulse: leave IDLE and begin joining
- cfg_continuous  in  1  1 = stay in RUN across frames; 0 = return to IDLE after one frame
- cfg_stop  in  1  pulse: return to IDLE at next frame boundary
- err_clear  in  1  pulse: clear err_misalign
- s{0..3}_tdata  in  SDATA_WIDTH  channel samples
- s{0..3}_tvalid / s{0..3}_tlast  in  1  channel handshake / frame end
- s{0..3}_tready  out  1  channel accept
- m_tdata  out  SDATA_WIDTH  saturated lane sums
- m_tvalid / m_tlast  out  1  output handshake / frame end
- m_tready  in  1  downstream accept
- busy  out  1  state != IDLE
- frame_count  out  32  completed output frames, wraps at 2^32
- err_misalign  out  1  sticky tlast-mismatch flag

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: all s*_tready = 0. On cfg_start with nonzero mask, latch mask into mask_q and go to RUN. cfg_start with mask = 0 is ignored.
- Join condition in RUN: every enabled channel has tvalid = 1 and (!m_tvalid || m_tready).
- When the join condition holds, every enabled s*_tready = 1 in that cycle.
- Disabled channels: tready = 1 in RUN/FLUSH. Their beats are discarded, and they contribute 0 to the sum.
- Sum per lane: sign-extend the enabled inputs to SSAMPLE_WIDTH+2 bits and add, then saturate to [-2^15, 2^15-1].
- tlast on a joined beat:
  - All enabled tlast = 0: m_tlast = 0.
  - All enabled tlast = 1: m_tlast = 1 and frame_count increments. Next state is IDLE if !cfg_continuous or a stop is pending; otherwise stay in RUN.
  - Mixed: m_tlast = 1, err_misalign set, frame_count unchanged, go to FLUSH. Channels that presented tlast = 1 are marked done.
- FLUSH:
  - Channels not yet done: tready = 1, beats discarded until their tlast beat is accepted, then marked done.
  - Done channels: tready = 0.
  - When all enabled channels are done, go to RUN (or IDLE under the same rule as above). No output beats are produced in FLUSH.
- cfg_stop sets stop_pending, which is cleared on entering IDLE. A stop arriving while in IDLE has no effect.
- err_clear clears err_misalign. If a set and a clear occur in the same cycle, the set wins.
- A disabled channel's tlast is ignored.

## Timing
- Reset (synchronous): state = IDLE; all s*_tready, m_tvalid, m_tlast, busy, err_misalign = 0; m_tdata = 0; frame_count = 0; mask_q = 0; stop_pending = 0.
- Reset mid-frame drops the output register contents and any partial frame, with no flush.
- Latency: a join at cycle N produces m_tvalid = 1 at cycle N+1.
- Throughput: 1 beat/cycle while m_tready is held at 1.
- The output register holds m_tdata/m_tlast stable while m_tvalid && !m_tready. m_tvalid falls after an accept unless a new join occurs in the same cycle.
- s*_tready is combinational from state, mask_q, the other channels' tvalid, m_tvalid and m_tready. No channel's tready depends on its own tvalid.
- Mask changes after start have no effect until the next IDLE→RUN transition.

## Structure
- Package quad_sum_pkg holds:
  - NUM_CH = 4
  - the state enum {IDLE, RUN, FLUSH}
  - a sat_sample function (SSAMPLE_WIDTH+2 → SSAMPLE_WIDTH)
- Sub-module quad_sample_sum: combinational, masked, per-lane saturating add of the four beats.
- The controller instantiates quad_sample_sum and owns the FSM, join logic, output register and counters.

## Test plan
- Mask 4'b1111, all lanes 0x0001 on each channel, 4-beat frame, m_tready = 1 → four beats, each lane 0x0004, tlast on beat 4, frame_count = 1, back to IDLE when cfg_continuous = 0.
- Mask 4'b0101, lanes 0x7000 on ch0 and ch2 → lanes 0x7FFF (positive saturation). Lanes 0x8000+0x8000 → 0x8000 (negative saturation). Beats on ch1/ch3 are discarded.
- ch3 tvalid withheld 5 cycles with mask 4'b1111 → no s*_tready and no output. A join occurs in the cycle ch3 asserts tvalid, and m_tvalid follows one cycle later.
- m_tready = 0 for 3 cycles with output valid → m_tdata/m_tlast stable, all s*_tready = 0. Resume gives 1 beat/cycle with no loss or duplication.
- ch1 asserts tlast on beat 2 while the others assert it on beat 4 → m_tlast on beat 2, err_misalign = 1, FLUSH discards 2 beats on each of ch0/2/3, then RUN. err_clear → 0.
- resetn = 0 mid-frame with m_tvalid = 1 → next cycle all outputs are at reset values, frame_count = 0, state IDLE.

Source files
------------

// File: rtl/quad_sum_pkg.sv
`default_nettype none
// ============================================================================
// quad_sum_pkg : shared types, constants and sample saturation helper
// Rev 1.0
// ============================================================================
package quad_sum_pkg;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic signed [SAMPLE_W+1:0] SAT_MAX = {3'b000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W+1:0] SAT_MIN = {3'b111, {(SAMPLE_W-1){1'b0}}};

  // Four sign-extended samples always fit in SAMPLE_W+2 bits, so clamping here is exact.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic signed [SAMPLE_W+1:0] x);
    if (x > SAT_MAX)
      return SAT_MAX[SAMPLE_W-1:0];
    else if (x < SAT_MIN)
      return SAT_MIN[SAMPLE_W-1:0];
    else
      return x[SAMPLE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_sum_ctrl_sample_sum.sv
`default_nettype none
// ============================================================================
// quad_sample_sum : masked per-lane saturating add of four beats
// Rev 1.0
// ============================================================================
module quad_sample_sum
  import quad_sum_pkg::*;
#(
  parameter int SDATA_WIDTH   = 256,
  parameter int SSAMPLE_WIDTH = SAMPLE_W
) (
  input  logic [NUM_CH-1:0]                  mask_i,
  input  logic [NUM_CH-1:0][SDATA_WIDTH-1:0] data_i,
  output logic [SDATA_WIDTH-1:0]             sum_o
);

  localparam int LANES = SDATA_WIDTH / SSAMPLE_WIDTH;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [SSAMPLE_WIDTH+1:0] acc;

    always_comb begin
      acc = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask_i[c])
          acc = acc + {{2{data_i[c][l*SSAMPLE_WIDTH + SSAMPLE_WIDTH-1]}},
                       data_i[c][l*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]};
      end
    end

    assign sum_o[l*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] = sat_sample(acc);
  end

endmodule
`default_nettype wire

// File: rtl/quad_sum_ctrl.sv
`default_nettype none
// ============================================================================
// quad_sum_ctrl : four-channel AXI4-Stream join, frame alignment and summing
// Rev 1.0
// ============================================================================
module quad_sum_ctrl
  import quad_sum_pkg::*;
#(
  parameter int SDATA_WIDTH   = 256,
  parameter int SSAMPLE_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   resetn,
  input  logic [NUM_CH-1:0]      cfg_enable_mask,
  input  logic                   cfg_start,
  input  logic                   cfg_continuous,
  input  logic                   cfg_stop,
  input  logic                   err_clear,
  input  logic [SDATA_WIDTH-1:0] s0_tdata,
  input  logic                   s0_tvalid,
  input  logic                   s0_tlast,
  output logic                   s0_tready,
  input  logic [SDATA_WIDTH-1:0] s1_tdata,
  input  logic                   s1_tvalid,
  input  logic                   s1_tlast,
  output logic                   s1_tready,
  input  logic [SDATA_WIDTH-1:0] s2_tdata,
  input  logic                   s2_tvalid,
  input  logic                   s2_tlast,
  output logic                   s2_tready,
  input  logic [SDATA_WIDTH-1:0] s3_tdata,
  input  logic                   s3_tvalid,
  input  logic                   s3_tlast,
  output logic                   s3_tready,
  output logic [SDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   busy,
  output logic [31:0]            frame_count,
  output logic                   err_misalign
);

  state_t                            state_q, state_d;
  logic [NUM_CH-1:0]                 mask_q, mask_d;
  logic [NUM_CH-1:0]                 done_q, done_d;
  logic                              stop_q, stop_d;
  logic                              err_q, err_d;
  logic [31:0]                       cnt_q, cnt_d;
  logic [SDATA_WIDTH-1:0]            mdata_q, mdata_d;
  logic                              mvalid_q, mvalid_d;
  logic                              mlast_q, mlast_d;

  logic [NUM_CH-1:0]                 tvalid, tlast, tready, last_en;
  logic [NUM_CH-1:0][SDATA_WIDTH-1:0] tdata;
  logic [SDATA_WIDTH-1:0]            sum_w;
  logic                              out_free, join_w, end_idle, err_set;

  assign tvalid = {s3_tvalid, s2_tvalid, s1_tvalid, s0_tvalid};
  assign tlast  = {s3_tlast, s2_tlast, s1_tlast, s0_tlast};
  assign tdata  = {s3_tdata, s2_tdata, s1_tdata, s0_tdata};

  assign out_free = !mvalid_q || m_tready;
  assign join_w   = (state_q == RUN) && (&(tvalid | ~mask_q)) && out_free;
  assign last_en  = tlast & mask_q;

  // Each channel's ready looks only at the other enabled channels' valid.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ready
    logic others_valid;
    assign others_valid = &(tvalid | ~mask_q | (NUM_CH'(1) << c));
    assign tready[c] = (state_q == RUN)   ? (!mask_q[c] || (others_valid && out_free)) :
                       (state_q == FLUSH) ? (!mask_q[c] || !done_q[c]) : 1'b0;
  end

  quad_sample_sum #(
    .SDATA_WIDTH   (SDATA_WIDTH),
    .SSAMPLE_WIDTH (SSAMPLE_WIDTH)
  ) u_sum (
    .mask_i (mask_q),
    .data_i (tdata),
    .sum_o  (sum_w)
  );

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q && !m_tready;
    mlast_d  = mlast_q;
    err_set  = 1'b0;
    end_idle = !cfg_continuous || stop_q || cfg_stop;

    case (state_q)
      IDLE: begin
        if (cfg_start && (|cfg_enable_mask)) begin
          mask_d  = cfg_enable_mask;
          done_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (join_w) begin
          mvalid_d = 1'b1;
          mdata_d  = sum_w;
          mlast_d  = |last_en;
          if (last_en == mask_q) begin
            cnt_d   = cnt_q + 32'd1;
            state_d = end_idle ? IDLE : RUN;
          end else if (|last_en) begin
            err_set = 1'b1;
            done_d  = last_en;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        done_d = done_q | (tvalid & tready & tlast & mask_q);
        if ((done_d & mask_q) == mask_q) begin
          done_d  = '0;
          state_d = end_idle ? IDLE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d  = err_set ? 1'b1 : (err_clear ? 1'b0 : err_q);
    stop_d = ((state_q == IDLE) || (state_d == IDLE)) ? 1'b0 : (stop_q || cfg_stop);
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      done_q   <= '0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      done_q   <= done_d;
      stop_q   <= stop_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
    end
  end

  assign s0_tready    = tready[0];
  assign s1_tready    = tready[1];
  assign s2_tready    = tready[2];
  assign s3_tready    = tready[3];
  assign m_tdata      = mdata_q;
  assign m_tvalid     = mvalid_q;
  assign m_tlast      = mlast_q;
  assign busy         = (state_q != IDLE);
  assign frame_count  = cnt_q;
  assign err_misalign = err_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_sum_ctrl.sv
`default_nettype none
// ============================================================================
// tb_quad_sum_ctrl : directed self-checking bench for quad_sum_ctrl
// Rev 1.0
// ============================================================================
module tb_quad_sum_ctrl;

  localparam int DW    = 256;
  localparam int LANES = DW / 16;

  logic          CLK = 1'b0;
  logic          resetn;
  logic [3:0]    cfg_enable_mask;
  logic          cfg_start, cfg_continuous, cfg_stop, err_clear;
  logic [DW-1:0] sd [4];
  logic [3:0]    sv, sl;
  logic          sr0, sr1, sr2, sr3;
  logic [3:0]    sr;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready, busy, err_misalign;
  logic [31:0]   frame_count;

  int nvec = 0;
  int nmis = 0;

  assign sr = {sr3, sr2, sr1, sr0};

  always #5 CLK = ~CLK;

  quad_sum_ctrl #(.SDATA_WIDTH(DW), .SSAMPLE_WIDTH(16)) dut (
    .CLK(CLK), .resetn(resetn),
    .cfg_enable_mask(cfg_enable_mask), .cfg_start(cfg_start),
    .cfg_continuous(cfg_continuous), .cfg_stop(cfg_stop), .err_clear(err_clear),
    .s0_tdata(sd[0]), .s0_tvalid(sv[0]), .s0_tlast(sl[0]), .s0_tready(sr0),
    .s1_tdata(sd[1]), .s1_tvalid(sv[1]), .s1_tlast(sl[1]), .s1_tready(sr1),
    .s2_tdata(sd[2]), .s2_tvalid(sv[2]), .s2_tlast(sl[2]), .s2_tready(sr2),
    .s3_tdata(sd[3]), .s3_tvalid(sv[3]), .s3_tlast(sl[3]), .s3_tready(sr3),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .frame_count(frame_count), .err_misalign(err_misalign)
  );

  function automatic logic [DW-1:0] rep(input logic [15:0] v);
    return {LANES{v}};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cfg_enable_mask = 4'b0; cfg_start = 0; cfg_continuous = 0;
    cfg_stop = 0; err_clear = 0; sv = 4'b0; sl = 4'b0; m_tready = 1'b1;
    for (int c = 0; c < 4; c++) sd[c] = '0;
    step(); step();
    nvec++; if (busy !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || err_misalign !== 1'b0) begin
      nmis++; $display("FAIL reset_flags got busy=%b tv=%b tl=%b err=%b want 0000", busy, m_tvalid, m_tlast, err_misalign);
    end
    nvec++; if (m_tdata !== '0 || frame_count !== 32'd0) begin
      nmis++; $display("FAIL reset_data got tdata=%h fc=%0d want 0/0", m_tdata, frame_count);
    end
    nvec++; if (sr !== 4'b0) begin
      nmis++; $display("FAIL reset_tready got %b want 0000", sr);
    end
    resetn = 1'b1;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    nvec++; if (busy !== 1'b0) begin
      nmis++; $display("FAIL start_zero_mask got busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic_frame();
    cfg_enable_mask = 4'b1111; cfg_continuous = 1'b0; m_tready = 1'b1;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    nvec++; if (busy !== 1'b1) begin
      nmis++; $display("FAIL basic_start got busy=%b want 1", busy);
    end
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 4; c++) sd[c] = rep(16'h0001);
      sv = 4'hF; sl = (b == 3) ? 4'hF : 4'h0;
      #1;
      nvec++; if (sr !== 4'hF) begin
        nmis++; $display("FAIL basic_tready beat %0d got %b want 1111", b, sr);
      end
      step();
      nvec++; if (m_tvalid !== 1'b1 || m_tdata !== rep(16'h0004) || m_tlast !== (b == 3)) begin
        nmis++; $display("FAIL basic_beat %0d got tv=%b tl=%b data=%h want 1/%0b/%h", b, m_tvalid, m_tlast, m_tdata, (b == 3), rep(16'h0004));
      end
    end
    sv = 4'h0; sl = 4'h0;
    nvec++; if (busy !== 1'b0 || frame_count !== 32'd1) begin
      nmis++; $display("FAIL basic_end got busy=%b fc=%0d want 0/1", busy, frame_count);
    end
    step();
    nvec++; if (m_tvalid !== 1'b0) begin
      nmis++; $display("FAIL basic_drain got tv=%b want 0", m_tvalid);
    end
  endtask

  task automatic test_saturation();
    cfg_enable_mask = 4'b0101; cfg_continuous = 1'b1;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    sd[0] = rep(16'h7000); sd[2] = rep(16'h7000); sd[1] = rep(16'h1234); sd[3] = rep(16'h1234);
    sv = 4'hF; sl = 4'h0;
    #1;
    nvec++; if (sr !== 4'hF) begin
      nmis++; $display("FAIL sat_tready got %b want 1111", sr);
    end
    step();
    nvec++; if (m_tdata !== rep(16'h7FFF) || m_tlast !== 1'b0) begin
      nmis++; $display("FAIL sat_pos got data=%h tl=%b want %h/0", m_tdata, m_tlast, rep(16'h7FFF));
    end
    sd[0] = rep(16'h8000); sd[2] = rep(16'h8000); sd[1] = rep(16'h7FFF); sd[3] = rep(16'h7FFF);
    sl = 4'b0111;
    step();
    nvec++; if (m_tdata !== rep(16'h8000) || m_tlast !== 1'b1) begin
      nmis++; $display("FAIL sat_neg got data=%h tl=%b want %h/1", m_tdata, m_tlast, rep(16'h8000));
    end
    nvec++; if (frame_count !== 32'd2 || busy !== 1'b1) begin
      nmis++; $display("FAIL sat_continuous got fc=%0d busy=%b want 2/1", frame_count, busy);
    end
    sv = 4'b1010; sl = 4'h0;
    #1;
    nvec++; if (sr !== 4'b1010) begin
      nmis++; $display("FAIL sat_disabled_ready got %b want 1010", sr);
    end
    step();
    nvec++; if (m_tvalid !== 1'b0) begin
      nmis++; $display("FAIL sat_no_join got tv=%b want 0", m_tvalid);
    end
    sv = 4'h0; cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
    nvec++; if (busy !== 1'b1) begin
      nmis++; $display("FAIL stop_waits got busy=%b want 1", busy);
    end
    sd[0] = rep(16'h0003); sd[2] = rep(16'hFFFF); sd[1] = rep(16'h7FFF); sd[3] = rep(16'h7FFF);
    sv = 4'hF; sl = 4'b0101;
    step();
    nvec++; if (m_tdata !== rep(16'h0002) || m_tlast !== 1'b1 || busy !== 1'b0 || frame_count !== 32'd3) begin
      nmis++; $display("FAIL stop_frame got data=%h tl=%b busy=%b fc=%0d want %h/1/0/3", m_tdata, m_tlast, busy, frame_count, rep(16'h0002));
    end
    sv = 4'h0; sl = 4'h0;
    step();
  endtask

  task automatic test_stall();
    cfg_enable_mask = 4'b1111; cfg_continuous = 1'b1;
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    for (int c = 0; c < 4; c++) sd[c] = rep(16'(c + 1));
    sv = 4'b0111; sl = 4'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++; if (sr[2:0] !== 3'b000) begin
        nmis++; $display("FAIL stall_tready cycle %0d got %b want x000", i, sr);
      end
      step();
      nvec++; if (m_tvalid !== 1'b0) begin
        nmis++; $display("FAIL stall_out cycle %0d got tv=%b want 0", i, m_tvalid);
      end
    end
    sv = 4'hF;
    #1;
    nvec++; if (sr !== 4'hF || m_tvalid !== 1'b0) begin
      nmis++; $display("FAIL stall_join got tready=%b tv=%b want 1111/0", sr, m_tvalid);
    end
    step();
    nvec++; if (m_tvalid !== 1'b1 || m_tdata !== rep(16'h000A)) begin
      nmis++; $display("FAIL stall_latency got tv=%b data=%h want 1/%h", m_tvalid, m_tdata, rep(16'h000A));
    end
  endtask

  task automatic test_back_to_back();
    m_tready = 1'b0;
    for (int c = 0; c < 4; c++) sd[c] = rep(16'h0010);
    sv = 4'hF; sl = 4'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (sr !== 4'h0) begin
        nmis++; $display("FAIL bp_tready cycle %0d got %b want 0000", i, sr);
      end
      step();
      nvec++; if (m_tvalid !== 1'b1 || m_tdata !== rep(16'h000A) || m_tlast !== 1'b0) begin
        nmis++; $display("FAIL bp_hold cycle %0d got tv=%b tl=%b data=%h want 1/0/%h", i, m_tvalid, m_tlast, m_tdata, rep(16'h000A));
      end
    end
    m_tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      for (int c = 0; c < 4; c++) sd[c] = rep(16'(16 * k));
      sl = (k == 4) ? 4'hF : 4'h0;
      #1;
      nvec++; if (sr !== 4'hF) begin
        nmis++; $display("FAIL b2b_tready beat %0d got %b want 1111", k, sr);
      end
      step();
      nvec++; if (m_tvalid !== 1'b1 || m_tdata !== rep(16'(64 * k)) || m_tlast !== (k == 4)) begin
        nmis++; $display("FAIL b2b_beat %0d got tv=%b tl=%b data=%h want 1/%0b/%h", k, m_tvalid, m_tlast, m_tdata, (k == 4), rep(16'(64 * k)));
      end
    end
    nvec++; if (frame_count !== 32'd4 || busy !== 1'b1) begin
      nmis++; $display("FAIL b2b_end got fc=%0d busy=%b want 4/1", frame_count, busy);
    end
    sv = 4'h0; sl = 4'h0;
    step();
  endtask

  task automatic test_misalign();
    for (int c = 0; c < 4; c++) sd[c] = rep(16'h0001);
    sv = 4'hF; sl = 4'h0;
    step();
    nvec++; if (m_tvalid !== 1'b1 || m_tlast !== 1'b0) begin
      nmis++; $display("FAIL mis_beat1 got tv=%b tl=%b want 1/0", m_tvalid, m_tlast);
    end
    sl = 4'b0010;
    step();
    nvec++; if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || err_misalign !== 1'b1 || frame_count !== 32'd4 || busy !== 1'b1) begin
      nmis++; $display("FAIL mis_beat2 got tv=%b tl=%b err=%b fc=%0d busy=%b want 1/1/1/4/1", m_tvalid, m_tlast, err_misalign, frame_count, busy);
    end
    for (int f = 0; f < 2; f++) begin
      sl = (f == 1) ? 4'b1101 : 4'b0000;
      #1;
      nvec++; if (sr !== 4'b1101) begin
        nmis++; $display("FAIL flush_tready beat %0d got %b want 1101", f, sr);
      end
      step();
      nvec++; if (m_tvalid !== 1'b0 || err_misalign !== 1'b1) begin
        nmis++; $display("FAIL flush_out beat %0d got tv=%b err=%b want 0/1", f, m_tvalid, err_misalign);
      end
    end
    sl = 4'h0;
    #1;
    nvec++; if (sr !== 4'hF) begin
      nmis++; $display("FAIL flush_resume got tready=%b want 1111", sr);
    end
    step();
    nvec++; if (m_tvalid !== 1'b1 || m_tdata !== rep(16'h0004)) begin
      nmis++; $display("FAIL flush_run got tv=%b data=%h want 1/%h", m_tvalid, m_tdata, rep(16'h0004));
    end
    err_clear = 1'b1; step(); err_clear = 1'b0;
    nvec++; if (err_misalign !== 1'b0 || m_tvalid !== 1'b1) begin
      nmis++; $display("FAIL err_clear got err=%b tv=%b want 0/1", err_misalign, m_tvalid);
    end
  endtask

  task automatic test_reset_midframe();
    resetn = 1'b0;
    step();
    nvec++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || busy !== 1'b0) begin
      nmis++; $display("FAIL midrst_out got tv=%b tl=%b data=%h busy=%b want 0/0/0/0", m_tvalid, m_tlast, m_tdata, busy);
    end
    nvec++; if (frame_count !== 32'd0 || err_misalign !== 1'b0 || sr !== 4'h0) begin
      nmis++; $display("FAIL midrst_state got fc=%0d err=%b tready=%b want 0/0/0000", frame_count, err_misalign, sr);
    end
    resetn = 1'b1; sv = 4'h0;
    step();
    nvec++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      nmis++; $display("FAIL midrst_idle got busy=%b tv=%b want 0/0", busy, m_tvalid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_misalign();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
